// File: rtl/div_if.sv
// Handshake and data bundle for the sequential signed divider.
// The requester drives the start strobe and operands; the divider returns the quotient and status.
interface div_if;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/div_sequencer.sv
// 32-bit signed restoring divider: one quotient bit per cycle, truncation toward zero.
// A start strobe restarts the operation from any state; results appear 34 edges after acceptance.
module div_sequencer (
  input  logic   clk,
  input  logic   reset,
  div_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  state_t      state;
  logic [31:0] quo;        // |A| shifts out the top while quotient bits shift in the bottom
  logic [31:0] divisor;
  logic [32:0] rem;
  logic [5:0]  cnt;
  logic        neg;
  logic        div_zero;
  logic        overflow;
  logic [31:0] q_fix;
  logic        e_fix;

  logic [31:0] result_q;
  logic        exception_q;
  logic        rdy_q;
  logic        busy_q;

  logic [33:0] rem_shift;
  logic [33:0] diff;
  logic        ge;
  logic [32:0] rem_next;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  always_comb begin
    rem_shift = {rem, quo[31]};
    diff      = rem_shift - {2'b00, divisor};
    ge        = ~diff[33];
    rem_next  = ge ? diff[32:0] : rem_shift[32:0];
    // Negating INT_MIN wraps back to 0x80000000, which is the correct unsigned magnitude.
    abs_a     = bus.data_operandA[31] ? -bus.data_operandA : bus.data_operandA;
    abs_b     = bus.data_operandB[31] ? -bus.data_operandB : bus.data_operandB;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      quo         <= '0;
      divisor     <= '0;
      rem         <= '0;
      cnt         <= '0;
      neg         <= 1'b0;
      div_zero    <= 1'b0;
      overflow    <= 1'b0;
      q_fix       <= '0;
      e_fix       <= 1'b0;
      result_q    <= '0;
      exception_q <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (bus.ctrl_DIV) begin
        // A strobe always wins: it aborts whatever is in flight, including a pending DONE.
        quo      <= abs_a;
        divisor  <= abs_b;
        neg      <= bus.data_operandA[31] ^ bus.data_operandB[31];
        div_zero <= (bus.data_operandB == '0);
        overflow <= (bus.data_operandA == INT_MIN) && (bus.data_operandB == '1);
        rem      <= '0;
        cnt      <= '0;
        busy_q   <= 1'b1;
        state    <= RUN;
      end else begin
        unique case (state)
          IDLE: busy_q <= 1'b0;
          RUN: begin
            rem <= rem_next;
            quo <= {quo[30:0], ge};
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) state <= FIX;
          end
          FIX: begin
            q_fix <= div_zero ? '0 : (neg ? -quo : quo);
            e_fix <= div_zero | overflow;
            state <= DONE;
          end
          DONE: begin
            result_q    <= q_fix;
            exception_q <= e_fix;
            rdy_q       <= 1'b1;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exception_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: the driver predicts quotient, flag and completion edge,
// and a negedge monitor compares every cycle against the predicted outputs.
module tb_div_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  div_if bus ();

  div_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          busy_end = -1;
  logic [31:0] hold_res = '0;
  logic        hold_exc = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: plain signed division with the two exceptional operand pairs handled explicitly.
  function automatic exp_t model(input logic signed [31:0] a, input logic signed [31:0] b, input int due);
    exp_t e;
    e.due = due;
    if (b == 0) begin
      e.res = 32'h0;
      e.exc = 1'b1;
    end else if (a == 32'sh8000_0000 && b == -32'sd1) begin
      e.res = 32'h8000_0000;
      e.exc = 1'b1;
    end else begin
      e.res = a / b;
      e.exc = 1'b0;
    end
    return e;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input int hold);
    @(negedge clk);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      sb.delete();
      sb.push_back(model(a, b, cyc + 34));
      busy_end = cyc + 34;
    end
    @(negedge clk);
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #2;
    reset = 1'b1;
    sb.delete();
    busy_end = -1;
    hold_res = '0;
    hold_exc = 1'b0;
    #1;
    check("rst_result", bus.data_result, 32'h0);
    check("rst_exception", {31'b0, bus.data_exception}, 32'h0);
    check("rst_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = 32'd77;
    bus.data_operandB = 32'd7;
    repeat (cycles) @(negedge clk);
    #2;
    reset        = 1'b0;
    bus.ctrl_DIV = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("in_rst_result", bus.data_result, 32'h0);
      check("in_rst_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
      check("in_rst_busy", {31'b0, bus.busy}, 32'h0);
    end else begin
      automatic logic exp_rdy = (sb.size() > 0) && (sb[0].due == cyc);
      check("rdy", {31'b0, bus.data_resultRDY}, {31'b0, exp_rdy});
      if (exp_rdy) begin
        automatic exp_t e = sb.pop_front();
        hold_res = e.res;
        hold_exc = e.exc;
      end
      check("result", bus.data_result, hold_res);
      check("exception", {31'b0, bus.data_exception}, {31'b0, hold_exc});
      check("busy", {31'b0, bus.busy}, {31'b0, (cyc <= busy_end)});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    do_reset(3);

    // Basic, sign and exceptional cases, each run to completion.
    issue(32'd100, 32'd7, 1);
    repeat (40) @(posedge clk);
    repeat (50) @(posedge clk);
    issue(-32'sd7, 32'd2, 1);
    repeat (38) @(posedge clk);
    issue(-32'sd9, -32'sd3, 1);
    repeat (38) @(posedge clk);
    issue(32'd5, 32'd0, 1);
    repeat (38) @(posedge clk);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1);
    repeat (38) @(posedge clk);

    // Restart ten edges into a run; the aborted op must never complete.
    issue(32'd50, 32'd5, 1);
    repeat (9) @(posedge clk);
    issue(32'd9, 32'd3, 1);
    repeat (40) @(posedge clk);

    // Strobe held for several edges restarts each time.
    issue(32'd1000, 32'd10, 4);
    repeat (40) @(posedge clk);

    // Reset in the middle of a run, then a clean op.
    issue(32'd100, 32'd7, 1);
    repeat (19) @(posedge clk);
    do_reset(2);
    issue(32'd12, 32'd4, 1);
    repeat (40) @(posedge clk);

    // Randomized operands and gaps, including aborts at every phase.
    for (int i = 0; i < 40; i++) begin
      automatic logic [31:0] a = $urandom;
      automatic logic [31:0] b;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'($signed($urandom_range(0, 15)) - 8);
        2:       begin a = 32'h8000_0000; b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      issue(a, b, $urandom_range(1, 2));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 36)) @(posedge clk);
      else repeat ($urandom_range(34, 45)) @(posedge clk);
    end

    repeat (40) @(posedge clk);
    check("drain", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
